// File: rtl/branch_history_predictor.sv
// Two-bit saturating-counter branch predictor with an in-order queue of in-flight predictions.
// Define BP_GLOBAL_HISTORY_EN for gshare indexing (PC bits XOR global history); default is bimodal.
module branch_history_predictor #(
    parameter int IDX_BITS = 6,
    parameter int DEPTH    = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        Instr_valid,
    input  logic [31:0] Instr_input,
    input  logic [31:0] Instr_addr_input,
    output logic        Taken,
    input  logic        Branch_resolved,
    input  logic        Branch_taken_actual,
    output logic        Predicted_taken_MEM,
    output logic        Mispredict,
    output logic        Queue_empty,
    output logic        Queue_full,
    output logic        Overflow
);
    localparam int TBL_SIZE = 1 << IDX_BITS;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    logic [1:0]          ctr_q [TBL_SIZE];
    logic [IDX_BITS-1:0] q_idx_q [DEPTH];
    logic                q_pred_q [DEPTH];
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                taken_q, overflow_q;

    logic [5:0]          opcode;
    logic                is_branch;
    logic [IDX_BITS-1:0] pc_idx, lookup_idx, train_idx;
    logic [1:0]          lookup_ctr, train_ctr, train_next;
    logic                accept, push_req, push, drop, pop;
    logic                unused_bits;

    assign opcode      = Instr_input[31:26];
    assign pc_idx      = Instr_addr_input[IDX_BITS+1:2];
    assign unused_bits = ^{Instr_input[25:0], Instr_addr_input[31:IDX_BITS+2], Instr_addr_input[1:0]};

    always_comb begin
        is_branch = 1'b0;
        case (opcode)
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: is_branch = 1'b1;
            default:                           is_branch = 1'b0;
        endcase
    end

`ifdef BP_GLOBAL_HISTORY_EN
    logic [IDX_BITS-1:0] ghr_q;

    // History only advances on resolution, so a flush never needs to repair it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ghr_q <= '0;
        end else if (pop) begin
            ghr_q <= {ghr_q[IDX_BITS-2:0], Branch_taken_actual};
        end
    end

    assign lookup_idx = pc_idx ^ ghr_q;
`else
    assign lookup_idx = pc_idx;
`endif

    assign Queue_empty = (count_q == '0);
    assign Queue_full  = (count_q == CNT_W'(DEPTH));

    assign accept   = Instr_valid & ~STALL & ~FLUSH;
    assign push_req = accept & is_branch;
    assign pop      = Branch_resolved & ~Queue_empty;
    assign push     = push_req & (~Queue_full | pop);
    assign drop     = push_req & Queue_full & ~pop;

    assign lookup_ctr = ctr_q[lookup_idx];
    assign train_idx  = q_idx_q[head_q];
    assign train_ctr  = ctr_q[train_idx];

    always_comb begin
        train_next = train_ctr;
        if (Branch_taken_actual) begin
            if (train_ctr != 2'd3) train_next = train_ctr + 2'd1;
        end else begin
            if (train_ctr != 2'd0) train_next = train_ctr - 2'd1;
        end
    end

    // Nonblocking update gives read-before-write for a same-cycle lookup of the trained entry.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < TBL_SIZE; i++) ctr_q[i] <= 2'd1;
        end else if (pop) begin
            ctr_q[train_idx] <= train_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_idx_q[tail_q]  <= lookup_idx;
            q_pred_q[tail_q] <= lookup_ctr[1];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            taken_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) taken_q <= is_branch & lookup_ctr[1];
            if (drop) overflow_q <= 1'b1;
            if (FLUSH) begin
                head_q  <= tail_q;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + PTR_W'(1);
                if (pop)  head_q <= head_q + PTR_W'(1);
                count_q <= count_d;
            end
        end
    end

    assign Taken               = taken_q;
    assign Overflow            = overflow_q;
    assign Predicted_taken_MEM = ~Queue_empty & q_pred_q[head_q];
    assign Mispredict          = pop & (Branch_taken_actual != Predicted_taken_MEM);

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed bench for the bimodal build of branch_history_predictor (IDX_BITS=6, DEPTH=8).
module tb_branch_history_predictor;
    logic        CLK = 1'b0;
    logic        RESET, STALL, FLUSH, Instr_valid;
    logic [31:0] Instr_input, Instr_addr_input;
    logic        Taken, Branch_resolved, Branch_taken_actual;
    logic        Predicted_taken_MEM, Mispredict, Queue_empty, Queue_full, Overflow;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [31:0] BEQ  = 32'h1000_0003;
    localparam logic [31:0] ADDU = 32'h0085_1021;
    localparam logic [31:0] JMP  = 32'h0810_0000;
    localparam logic [31:0] PC4  = 32'h0040_0010;

    branch_history_predictor #(.IDX_BITS(6), .DEPTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .Instr_valid(Instr_valid), .Instr_input(Instr_input), .Instr_addr_input(Instr_addr_input),
        .Taken(Taken), .Branch_resolved(Branch_resolved), .Branch_taken_actual(Branch_taken_actual),
        .Predicted_taken_MEM(Predicted_taken_MEM), .Mispredict(Mispredict),
        .Queue_empty(Queue_empty), .Queue_full(Queue_full), .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
        $display("check %-28s observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
        Instr_valid = 1'b1; Instr_input = instr; Instr_addr_input = pc;
        tick();
        Instr_valid = 1'b0;
    endtask

    task automatic resolve(input logic actual, input logic exp_mis, input string tag);
        Branch_resolved = 1'b1; Branch_taken_actual = actual;
        #1;
        check(tag, Mispredict, exp_mis);
        tick();
        Branch_resolved = 1'b0;
    endtask

    // Each row: expected prediction for PC4, actual outcome, expected mispredict.
    logic [2:0] rounds [10] = '{3'b011, 3'b110, 3'b110, 3'b101, 3'b101,
                                3'b000, 3'b000, 3'b011, 3'b011, 3'b101};
    logic [31:0] br_ops [5] = '{32'h0400_0000, 32'h1000_0000, 32'h1400_0000,
                                32'h1800_0000, 32'h1C00_0000};

    initial begin
        RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0; Instr_valid = 1'b0;
        Instr_input = '0; Instr_addr_input = '0;
        Branch_resolved = 1'b0; Branch_taken_actual = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        check("reset_taken", Taken, 1'b0);
        check("reset_ptm", Predicted_taken_MEM, 1'b0);
        check("reset_mispredict", Mispredict, 1'b0);
        check("reset_empty", Queue_empty, 1'b1);
        check("reset_full", Queue_full, 1'b0);
        check("reset_overflow", Overflow, 1'b0);

        // Train one counter through both saturation limits.
        for (int r = 0; r < 10; r++) begin
            fetch(BEQ, PC4);
            check($sformatf("round%0d_taken", r), Taken, rounds[r][2]);
            check($sformatf("round%0d_ptm", r), Predicted_taken_MEM, rounds[r][2]);
            check($sformatf("round%0d_empty", r), Queue_empty, 1'b0);
            resolve(rounds[r][1], rounds[r][0], $sformatf("round%0d_mispredict", r));
            check($sformatf("round%0d_drained", r), Queue_empty, 1'b1);
        end

        fetch(ADDU, 32'h0040_0014);
        check("addu_taken", Taken, 1'b0);
        check("addu_no_push", Queue_empty, 1'b1);
        fetch(JMP, PC4);
        check("jump_no_push", Queue_empty, 1'b1);
        resolve(1'b1, 1'b0, "empty_resolve_mispredict");
        check("empty_resolve_empty", Queue_empty, 1'b1);
        fetch(BEQ, PC4);
        check("untrained_taken", Taken, 1'b0);
        resolve(1'b1, 1'b1, "retrain_mispredict");
        fetch(BEQ, PC4);
        check("ctr2_taken", Taken, 1'b1);

        STALL = 1'b1;
        fetch(32'h1400_0000, 32'h0040_0020);
        STALL = 1'b0;
        check("stall_hold_taken", Taken, 1'b1);
        resolve(1'b1, 1'b0, "stall_resolve_mispredict");
        check("stall_no_push", Queue_empty, 1'b1);

        // Fill the queue with predictions from untouched counters (all not-taken).
        for (int k = 0; k < 8; k++) begin
            fetch(br_ops[k % 5], 32'h0040_0020 + 32'(4 * k));
            check($sformatf("fill%0d_taken", k), Taken, 1'b0);
            check($sformatf("fill%0d_full", k), Queue_full, k == 7);
        end
        check("full_ptm", Predicted_taken_MEM, 1'b0);
        check("full_overflow_clear", Overflow, 1'b0);

        fetch(BEQ, PC4);
        check("drop_taken", Taken, 1'b1);
        check("drop_overflow", Overflow, 1'b1);
        check("drop_full", Queue_full, 1'b1);

        Instr_valid = 1'b1; Instr_input = BEQ; Instr_addr_input = PC4;
        resolve(1'b0, 1'b0, "pushpop_mispredict");
        Instr_valid = 1'b0;
        check("pushpop_full", Queue_full, 1'b1);
        check("pushpop_ptm", Predicted_taken_MEM, 1'b0);

        for (int k = 0; k < 5; k++) resolve(1'b0, 1'b0, $sformatf("drain%0d_mispredict", k));
        check("three_left_full", Queue_full, 1'b0);
        check("three_left_empty", Queue_empty, 1'b0);

        // Head is idx 14 (predicted not-taken); flush alongside a taken resolve and a fetch.
        FLUSH = 1'b1;
        Instr_valid = 1'b1; Instr_input = BEQ; Instr_addr_input = 32'h0040_0020;
        resolve(1'b1, 1'b1, "flush_mispredict");
        FLUSH = 1'b0; Instr_valid = 1'b0;
        check("flush_empty", Queue_empty, 1'b1);
        check("flush_taken_hold", Taken, 1'b1);
        check("flush_ptm", Predicted_taken_MEM, 1'b0);
        fetch(BEQ, 32'h0040_0038);
        check("flush_trained_taken", Taken, 1'b1);
        check("flush_trained_ptm", Predicted_taken_MEM, 1'b1);

        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("midreset_taken", Taken, 1'b0);
        check("midreset_empty", Queue_empty, 1'b1);
        check("midreset_overflow", Overflow, 1'b0);
        check("midreset_ptm", Predicted_taken_MEM, 1'b0);
        fetch(BEQ, 32'h0040_0038);
        check("midreset_ctr14", Taken, 1'b0);
        fetch(BEQ, PC4);
        check("midreset_ctr4", Taken, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/branch_history_predictor.md
# branch_history_predictor

- Two-bit saturating-counter branch predictor, drop-in replacement for the always-not-taken predictor beside the IF stage.
- Looks up each fetched instruction in a counter table and registers a taken/not-taken prediction.
- Keeps an in-order queue of in-flight branch predictions, which MEM consumes when it resolves a branch.
- Trains the table on resolution and signals mispredicts, which drive the pipeline FLUSH.

## Interface
Parameters:
- IDX_BITS, 6: table index width; table holds 2^IDX_BITS 2-bit counters.
- DEPTH, 8: in-flight prediction queue entries (power of two, ≥2).

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high.
- STALL  in  1  pipeline freeze from ID; blocks lookup and push.
- FLUSH  in  1  squash from MEM; empties queue.
- Instr_valid  in  1  Instr_input/Instr_addr_input hold a real fetched instruction.
- Instr_input  in  32  fetched instruction word.
- Instr_addr_input  in  32  PC of fetched instruction.
- Taken  out  1  registered prediction for the last accepted instruction.
- Branch_resolved  in  1  MEM resolves the oldest in-flight branch this cycle.
- Branch_taken_actual  in  1  actual outcome of the resolving branch.
- Predicted_taken_MEM  out  1  prediction at queue head; 0 when empty.
- Mispredict  out  1  combinational: Branch_resolved & !empty & (Branch_taken_actual != Predicted_taken_MEM).
- Queue_empty  out  1  no in-flight predictions.
- Queue_full  out  1  DEPTH entries held.
- Overflow  out  1  sticky: a branch push was dropped because the queue was full.

## Operation
- Branch decode: opcode Instr_input[31:26] ∈ {0x01 REGIMM, 0x04 BEQ, 0x05 BNE, 0x06 BLEZ, 0x07 BGTZ}. Jumps (0x02, 0x03, JR) are not branches.
- Lookup index idx = Instr_addr_input[IDX_BITS+1:2], modified per Configuration.
- Accept is Instr_valid & !STALL & !FLUSH.
  - On accept, Taken <= is_branch & ctr[idx][1].
  - On a non-branch accept, Taken <= 0.
  - Without accept, Taken holds.
- Push: accept & is_branch writes entry {idx, ctr[idx][1]} at the tail.
- Pop: Branch_resolved & !empty removes the head.
- Training on pop: ctr[head.idx] saturates toward the outcome.
  - Taken outcome: +1, capped at 3.
  - Not-taken outcome: −1, floored at 0.
  - Encoding: 0 = strong NT, 1 = weak NT, 2 = weak T, 3 = strong T.
- Branch_resolved while empty: no pop, no training, Mispredict = 0.
- Full queue:
  - A push is accepted when it coincides with a pop.
  - Otherwise the push is dropped and Overflow is set.
  - Taken is still updated for a dropped push.
- FLUSH:
  - Queue is empty next cycle: head = tail, count = 0.
  - A same-cycle pop still trains the table.
  - A same-cycle push is discarded.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update counter (read-before-write).
- RESET:
  - All counters = 1 (weak NT).
  - Queue emptied, GHR = 0.
  - Taken = 0, Overflow = 0.
  - Reset mid-operation discards all in-flight state.

## Timing
- Lookup latency 1 cycle: an instruction accepted at edge N gives Taken valid after edge N.
- Predicted_taken_MEM, Queue_empty and Queue_full are registered state; Mispredict is combinational, valid in the resolving cycle.
- A training update is visible to lookups from the cycle after the pop edge.
- Reset values: Taken = 0, Predicted_taken_MEM = 0, Mispredict = 0, Queue_empty = 1, Queue_full = 0, Overflow = 0.
- Queue pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Configuration
- BP_GLOBAL_HISTORY_EN defined (gshare):
  - An IDX_BITS global history register GHR is added.
  - Lookup index is Instr_addr_input[IDX_BITS+1:2] ^ GHR.
  - On every pop, GHR <= {GHR[IDX_BITS-2:0], Branch_taken_actual}. The update is non-speculative and is not cleared by FLUSH.
  - Queue entries carry the index used at lookup, so training hits the same counter.
- BP_GLOBAL_HISTORY_EN undefined: pure bimodal; no GHR register; index is PC bits only.

## Test plan
- Reset, then fetch BEQ (0x10000003) at 0x00400010 -> Taken=0, Queue_empty=0, Predicted_taken_MEM=0 (counter 1).
- Resolve that branch taken twice (two fetch/resolve rounds), then fetch it again -> Taken=1; a third taken resolve leaves counter at 3; four not-taken resolves saturate at 0.
- Fetch ADDU 0x00851021 -> Taken=0, no push. Assert Branch_resolved on an empty queue -> Mispredict=0, counters unchanged.
- Push 8 branches without resolution (DEPTH=8) -> Queue_full=1. Push a ninth -> dropped, Overflow=1. Ninth push with a simultaneous pop -> accepted, Queue_full stays 1.
- With 3 entries queued, assert FLUSH together with Branch_resolved=1 and actual ≠ head -> Mispredict=1, head counter trained, Queue_empty=1 next cycle.
- BP_GLOBAL_HISTORY_EN defined, IDX_BITS=6: resolve pattern T,T,NT -> GHR=6'b000110. Next lookup at PC 0x00400010 uses index 0x04^0x06=0x02.
